// File: rtl/prog_clock_div_pkg.sv
// Shared definitions for the programmable clock divider: default geometry,
// reset divisor, load-index width and the per-channel action encoding.
package prog_clock_div_pkg;

  localparam int unsigned CH_DEF          = 4;
  localparam int unsigned W_DEF           = 16;
  localparam int unsigned DEFAULT_DIV_DEF = 50000;
  localparam int unsigned LOAD_CH_W       = 3;

  typedef enum logic [2:0] {
    ACT_HOLD  = 3'd0,
    ACT_COUNT = 3'd1,
    ACT_WRAP  = 3'd2,
    ACT_LOAD  = 3'd3,
    ACT_SYNC  = 3'd4
  } chan_act_e;

endpackage

// File: rtl/div_channel.sv
// One divider channel: divisor, counter, divided clock and terminal-count tick,
// all clocked by the single input clock.
module div_channel
  import prog_clock_div_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned RST_DIV = DEFAULT_DIV_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_sync,
  output logic         o_clkout,
  output logic         o_tick
);

  logic [W-1:0] r_div;
  logic [W-1:0] r_cnt;
  logic         r_clkout;
  logic         r_tick;

  chan_act_e    w_act;
  logic [W-1:0] w_div_nxt;
  logic [W-1:0] w_cnt_nxt;
  logic         w_clkout_nxt;
  logic         w_tick_nxt;

  // SYNC dominates LOAD for CNT/CLKOUT, but a coincident LOAD still writes DIV.
  always_comb begin
    w_act = ACT_HOLD;
    if (i_sync) begin
      w_act = ACT_SYNC;
    end else if (i_load) begin
      w_act = ACT_LOAD;
    end else if (i_en && (r_div != {W{1'b0}})) begin
      w_act = (r_cnt >= (r_div - 1'b1)) ? ACT_WRAP : ACT_COUNT;
    end else begin
      w_act = ACT_HOLD;
    end
  end

  always_comb begin
    w_div_nxt    = i_load ? i_load_val : r_div;
    w_cnt_nxt    = r_cnt;
    w_clkout_nxt = r_clkout;
    w_tick_nxt   = 1'b0;
    case (w_act)
      ACT_SYNC: begin
        w_cnt_nxt    = {W{1'b0}};
        w_clkout_nxt = 1'b0;
      end
      ACT_LOAD:  w_cnt_nxt = {W{1'b0}};
      ACT_COUNT: w_cnt_nxt = r_cnt + 1'b1;
      ACT_WRAP: begin
        w_cnt_nxt    = {W{1'b0}};
        w_tick_nxt   = 1'b1;
        w_clkout_nxt = ~r_clkout;
      end
      ACT_HOLD:  w_cnt_nxt = r_cnt;
      default:   w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div    <= W'(RST_DIV);
      r_cnt    <= {W{1'b0}};
      r_clkout <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_div    <= w_div_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clkout <= w_clkout_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign o_clkout = r_clkout;
  assign o_tick   = r_tick;

endmodule

// File: rtl/prog_clock_div.sv
// Multi-channel programmable clock divider: decodes the shared LOAD bus and
// fans SYNC out to CH independent div_channel instances.
module prog_clock_div
  import prog_clock_div_pkg::*;
#(
  parameter int unsigned CH          = CH_DEF,
  parameter int unsigned W           = W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                 i_clkin,
  input  logic                 i_rst,
  input  logic [CH-1:0]        i_en,
  input  logic                 i_load,
  input  logic [LOAD_CH_W-1:0] i_load_ch,
  input  logic [W-1:0]         i_load_val,
  input  logic                 i_sync,
  output logic [CH-1:0]        o_clkout,
  output logic [CH-1:0]        o_tick
);

  logic [CH-1:0] w_load_hit;

  // An out-of-range LOAD_CH matches no channel and is dropped.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    assign w_load_hit[gi] = i_load && (i_load_ch == LOAD_CH_W'(gi));

    div_channel #(
      .W       (W),
      .RST_DIV (DEFAULT_DIV)
    ) u_chan (
      .i_clk      (i_clkin),
      .i_rst      (i_rst),
      .i_en       (i_en[gi]),
      .i_load     (w_load_hit[gi]),
      .i_load_val (i_load_val),
      .i_sync     (i_sync),
      .o_clkout   (o_clkout[gi]),
      .o_tick     (o_tick[gi])
    );
  end

endmodule
